spy_bus_ctrl: RTL and testbench
===============================

Name: spy_bus_ctrl

Overview:
Parametrised, registered successor to the combinational spy decoder. Accepts single read/write requests from the host debug interface (PDP11 / USB spy port) through a valid/ready handshake. Drives a one-hot read-select vector for a programmable number of settle cycles, samples the muxed spy read data, and issues single-cycle one-hot load strobes for writes. Returns a one-cycle response pulse with data and an error flag for out-of-range addresses. Sits between the host bus bridge and the processor's spy register muxes / load enables.

Parameters:
ADDR_W, 6, request address width
DATA_W, 16, spy data width
RD_COUNT, 24, number of readable spy addresses (0..RD_COUNT-1); 1 <= RD_COUNT <= 2**ADDR_W
WR_COUNT, 12, number of writable spy addresses (0..WR_COUNT-1); 1 <= WR_COUNT <= 2**ADDR_W
RD_LAT, 1, cycles rd_sel is held before rd_data is sampled; RD_LAT >= 1

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
req_valid  in  1  host request present
req_ready  out  1  block can accept a request (IDLE only)
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  spy register address
req_wdata  in  DATA_W  write data
rd_sel  out  RD_COUNT  one-hot read select to spy mux
rd_data  in  DATA_W  muxed spy read data
ld_stb  out  WR_COUNT  one-hot load strobe
ld_data  out  DATA_W  write data for loaded register
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read result (0 for writes and errors)
rsp_err  out  1  address out of range; valid with rsp_valid
busy  out  1  ~req_ready

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; req_ready=1; busy=0; rd_sel=0; ld_stb=0; ld_data=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; internal latency counter=0. Reset mid-transaction aborts the transaction: no strobe and no response is emitted afterwards.
- States: IDLE, RSEL, WSTB, RESP. All outputs registered.
- Acceptance: in IDLE, req_valid=1 at posedge T captures req_write, req_addr and req_wdata. req_ready is 1 only in IDLE. Requests while busy are ignored (not queued).
- Read in range (addr < RD_COUNT):
  - T+1..T+RD_LAT: RSEL, rd_sel[addr]=1 (exactly one bit).
  - rd_data is sampled at the posedge ending the last RSEL cycle.
  - T+RD_LAT+1: RESP, rsp_valid=1, rsp_rdata=sample, rsp_err=0, rd_sel=0.
  - T+RD_LAT+2: IDLE.
- Write in range (addr < WR_COUNT):
  - T+1: WSTB, ld_stb[addr]=1 for exactly one cycle; ld_data=wdata.
  - T+2: RESP, rsp_valid=1, rsp_rdata=0, rsp_err=0.
  - T+3: IDLE.
  - ld_data holds its value until the next in-range write.
- Out of range (read addr >= RD_COUNT or write addr >= WR_COUNT):
  - T+1: RESP directly, rsp_valid=1, rsp_err=1, rsp_rdata=0; no rd_sel or ld_stb activity; ld_data unchanged.
- rsp_valid is a one-cycle pulse with no backpressure. rsp_rdata and rsp_err hold their values until the next RESP.
- Throughput: back-to-back requests. A request held valid through RESP is accepted in the first IDLE cycle, giving one transaction per RD_LAT+2 cycles (read), 3 cycles (write) or 2 cycles (error).
- Invariants: rd_sel and ld_stb are never nonzero in the same cycle; each is at most one-hot.
- Address width rule: addresses are compared unsigned at full ADDR_W width, with no aliasing of upper bits.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles mid-read (RD_LAT=2) -> all outputs 0, req_ready=1, no rsp_valid after release.
2. Read addr 5, RD_LAT=2, rd_data=16'h1234 -> rd_sel=24'h000020 for exactly 2 cycles; rsp_valid at T+3 with rsp_rdata=16'h1234, rsp_err=0; req_ready back at T+4.
3. Write addr 11, wdata=16'hBEEF -> ld_stb=12'h800 for one cycle at T+1 with ld_data=16'hBEEF; rsp_valid at T+2, rsp_rdata=0; ld_data still 16'hBEEF after 10 idle cycles.
4. Read addr 30 and write addr 12 (out of range) -> rsp_valid at T+1, rsp_err=1, rsp_rdata=0; rd_sel and ld_stb stay 0; ld_data unchanged.
5. req_valid held high for write 0, read 1, write 2 -> accepted at cycles 0, 3 and 3+RD_LAT+2; exactly three rsp_valid pulses; ld_stb pulses 12'h001 then 12'h004.
6. rd_data changed every cycle during RSEL (RD_LAT=3) -> rsp_rdata equals the value present in the third RSEL cycle.

Source files
------------

// File: rtl/spy_bus_ctrl.sv
// Spy bus controller: turns host spy requests into one-hot read selects or load strobes and returns a response pulse.
// Latency: read rsp_valid RD_LAT+1 cycles after acceptance, write 2 cycles, out-of-range address 1 cycle.
// Backpressure: req_ready only in IDLE and requests while busy are dropped; rsp_valid is a pulse with no backpressure.
`timescale 1ns/1ps
module spy_bus_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int RD_COUNT = 24,
    parameter int WR_COUNT = 12,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic [RD_COUNT-1:0] rd_sel,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [WR_COUNT-1:0] ld_stb,
    output logic [DATA_W-1:0]   ld_data,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    // Settle counter runs 0..RD_LAT-1 while rd_sel is held.
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    // Limits carry one extra bit so RD_COUNT == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] RD_LIMIT = (ADDR_W + 1)'(RD_COUNT);
    localparam logic [ADDR_W:0] WR_LIMIT = (ADDR_W + 1)'(WR_COUNT);

    localparam logic [RD_COUNT-1:0] RD_ONE = RD_COUNT'(1);
    localparam logic [WR_COUNT-1:0] WR_ONE = WR_COUNT'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSEL = 2'd1,
        WSTB = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                req_ready_nxt;
    logic [RD_COUNT-1:0] rd_sel_nxt;
    logic [WR_COUNT-1:0] ld_stb_nxt;
    logic [DATA_W-1:0]   ld_data_nxt;
    logic                rsp_valid_nxt;
    logic [DATA_W-1:0]   rsp_rdata_nxt;
    logic                rsp_err_nxt;

    logic rd_in_range;
    logic wr_in_range;

    // Full-width unsigned range checks: upper address bits never alias into range.
    assign rd_in_range = {1'b0, req_addr} < RD_LIMIT;
    assign wr_in_range = {1'b0, req_addr} < WR_LIMIT;

    assign busy = ~req_ready;

    // Next-state and next-output decode; every output is computed here and registered below.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rd_sel_nxt    = rd_sel;
        ld_stb_nxt    = '0;
        ld_data_nxt   = ld_data;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_write && wr_in_range) begin
                        state_nxt   = WSTB;
                        ld_stb_nxt  = WR_ONE << req_addr;
                        ld_data_nxt = req_wdata;
                    end else if (!req_write && rd_in_range) begin
                        state_nxt  = RSEL;
                        rd_sel_nxt = RD_ONE << req_addr;
                        cnt_nxt    = '0;
                    end else begin
                        // Out of range: answer straight away with no bus activity.
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_rdata_nxt = '0;
                        rsp_err_nxt   = 1'b1;
                    end
                end
            end
            RSEL: begin
                if (cnt == CNT_LAST) begin
                    // Last settle cycle: capture the mux output as this edge closes it.
                    state_nxt     = RESP;
                    rd_sel_nxt    = '0;
                    cnt_nxt       = '0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = rd_data;
                    rsp_err_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WSTB: begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
                rsp_rdata_nxt = '0;
                rsp_err_nxt   = 1'b0;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                rd_sel_nxt = '0;
                cnt_nxt    = '0;
            end
        endcase

        req_ready_nxt = (state_nxt == IDLE);
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rd_sel    <= '0;
            ld_stb    <= '0;
            ld_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= req_ready_nxt;
            rd_sel    <= rd_sel_nxt;
            ld_stb    <= ld_stb_nxt;
            ld_data   <= ld_data_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_spy_bus_ctrl.sv
`timescale 1ns/1ps
module tb_spy_bus_ctrl;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 16;
    localparam int RD_COUNT = 24;
    localparam int WR_COUNT = 12;
    localparam int LAT_A    = 2;
    localparam int LAT_B    = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: RD_LAT = 2
    logic                a_req_valid, a_req_ready, a_req_write;
    logic [ADDR_W-1:0]   a_req_addr;
    logic [DATA_W-1:0]   a_req_wdata, a_rd_data, a_ld_data, a_rsp_rdata;
    logic [RD_COUNT-1:0] a_rd_sel;
    logic [WR_COUNT-1:0] a_ld_stb;
    logic                a_rsp_valid, a_rsp_err, a_busy;

    // Instance B: RD_LAT = 3
    logic                b_req_valid, b_req_ready, b_req_write;
    logic [ADDR_W-1:0]   b_req_addr;
    logic [DATA_W-1:0]   b_req_wdata, b_rd_data, b_ld_data, b_rsp_rdata;
    logic [RD_COUNT-1:0] b_rd_sel;
    logic [WR_COUNT-1:0] b_ld_stb;
    logic                b_rsp_valid, b_rsp_err, b_busy;

    // Last data written to an in-range register of instance A.
    logic [DATA_W-1:0] ld_model;

    spy_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_COUNT(RD_COUNT),
                   .WR_COUNT(WR_COUNT), .RD_LAT(LAT_A)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rd_sel(a_rd_sel), .rd_data(a_rd_data),
        .ld_stb(a_ld_stb), .ld_data(a_ld_data),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .busy(a_busy)
    );

    spy_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_COUNT(RD_COUNT),
                   .WR_COUNT(WR_COUNT), .RD_LAT(LAT_B)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rd_sel(b_rd_sel), .rd_data(b_rd_data),
        .ld_stb(b_ld_stb), .ld_data(b_ld_data),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on instance A, checked cycle by cycle against the protocol rules.
    // rdv < 0 gives random read data on every settle cycle.
    task automatic txn_a(input bit write, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int rdv);
        bit                  in_rng;
        logic [RD_COUNT-1:0] esel;
        logic [WR_COUNT-1:0] estb;
        logic [DATA_W-1:0]   sample;
        logic [DATA_W-1:0]   exp_rdata;
        in_rng = write ? (int'(addr) < WR_COUNT) : (int'(addr) < RD_COUNT);
        sample = '0;
        chk("ready_before", a_req_ready, 1);
        a_req_valid = 1'b1; a_req_write = write; a_req_addr = addr; a_req_wdata = wdata;
        step();
        // Scramble the request fields once accepted; the DUT must have captured them.
        a_req_valid = 1'b0; a_req_write = 1'($urandom);
        a_req_addr = ADDR_W'($urandom); a_req_wdata = DATA_W'($urandom);
        if (!in_rng) begin
            chk("err_rsp_valid", a_rsp_valid, 1);
            chk("err_rsp_err", a_rsp_err, 1);
            chk("err_rsp_rdata", a_rsp_rdata, 0);
            chk("err_rd_sel", a_rd_sel, 0);
            chk("err_ld_stb", a_ld_stb, 0);
            chk("err_ld_data", a_ld_data, ld_model);
            exp_rdata = '0;
        end else if (write) begin
            estb = '0; estb[addr] = 1'b1;
            ld_model = wdata;
            chk("wr_ld_stb", a_ld_stb, estb);
            chk("wr_ld_data", a_ld_data, wdata);
            chk("wr_rd_sel", a_rd_sel, 0);
            chk("wr_no_rsp", a_rsp_valid, 0);
            chk("wr_busy", a_busy, 1);
            step();
            chk("wr_rsp_valid", a_rsp_valid, 1);
            chk("wr_rsp_rdata", a_rsp_rdata, 0);
            chk("wr_rsp_err", a_rsp_err, 0);
            chk("wr_stb_cleared", a_ld_stb, 0);
            exp_rdata = '0;
        end else begin
            esel = '0; esel[addr] = 1'b1;
            for (int k = 0; k < LAT_A; k++) begin
                chk("rd_sel", a_rd_sel, esel);
                chk("rd_no_rsp", a_rsp_valid, 0);
                chk("rd_ld_stb", a_ld_stb, 0);
                chk("rd_ready", a_req_ready, 0);
                a_rd_data = (rdv < 0) ? DATA_W'($urandom) : DATA_W'(rdv);
                sample = a_rd_data;
                step();
            end
            chk("rd_rsp_valid", a_rsp_valid, 1);
            chk("rd_rsp_rdata", a_rsp_rdata, sample);
            chk("rd_rsp_err", a_rsp_err, 0);
            chk("rd_sel_cleared", a_rd_sel, 0);
            exp_rdata = sample;
        end
        step();
        chk("idle_ready", a_req_ready, 1);
        chk("idle_busy", a_busy, 0);
        chk("idle_rsp_pulse", a_rsp_valid, 0);
        chk("idle_rdata_hold", a_rsp_rdata, exp_rdata);
        chk("idle_err_hold", a_rsp_err, !in_rng);
    endtask

    initial begin
        int acc[3];
        int n_acc, n_rsp;
        bit take;
        logic [WR_COUNT-1:0] stb_seen[$];
        logic [DATA_W-1:0]   last_b;
        logic [RD_COUNT-1:0] esel;
        logic [ADDR_W-1:0]   addr;

        reset_n = 1'b0;
        a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wdata = '0; a_rd_data = '0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0; b_rd_data = '0;
        ld_model = '0;
        repeat (3) step();
        chk("rst_a_ready", a_req_ready, 1);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_rd_sel", a_rd_sel, 0);
        chk("rst_a_ld_stb", a_ld_stb, 0);
        chk("rst_a_ld_data", a_ld_data, 0);
        chk("rst_a_rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, 0);
        chk("rst_b_ready", b_req_ready, 1);
        chk("rst_b_outs", {b_busy, b_rd_sel, b_ld_stb, b_ld_data, b_rsp_valid, b_rsp_err, b_rsp_rdata}, 0);
        reset_n = 1'b1;
        step();

        // Reset in the middle of a read aborts it with no response afterwards.
        a_req_valid = 1; a_req_write = 0; a_req_addr = 6'd3;
        step();
        a_req_valid = 0;
        chk("pre_rst_rd_sel", a_rd_sel, 24'h000008);
        reset_n = 1'b0;
        repeat (3) step();
        chk("midrst_ready", a_req_ready, 1);
        chk("midrst_outs", {a_busy, a_rd_sel, a_ld_stb, a_ld_data, a_rsp_valid, a_rsp_err, a_rsp_rdata}, 0);
        reset_n = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (a_rsp_valid || a_rd_sel != 0) n_rsp++;
        end
        chk("post_rst_quiet", n_rsp, 0);

        // Directed read and write, including the ld_data hold.
        txn_a(0, 6'd5, 16'h0000, 32'h1234);
        txn_a(1, 6'd11, 16'hBEEF, -1);
        repeat (10) step();
        chk("ld_data_hold", a_ld_data, 16'hBEEF);

        // Range boundaries on both sides.
        txn_a(0, 6'd30, 16'h0, -1);
        txn_a(1, 6'd12, 16'h5555, -1);
        txn_a(0, 6'd23, 16'h0, -1);
        txn_a(0, 6'd24, 16'h0, -1);
        txn_a(1, 6'd0, 16'hA5A5, -1);
        txn_a(0, 6'd63, 16'h0, -1);
        txn_a(1, 6'd63, 16'h1111, -1);
        chk("ld_data_after_err", a_ld_data, 16'hA5A5);

        // Back-to-back: write 0, read 1, write 2 with valid held high.
        n_acc = 0; n_rsp = 0;
        a_req_valid = 1; a_req_write = 1; a_req_addr = 6'd0; a_req_wdata = 16'hC001;
        for (int c = 0; c < 20; c++) begin
            take = 0;
            if (a_rsp_valid) n_rsp++;
            if (a_ld_stb != 0) stb_seen.push_back(a_ld_stb);
            if (a_req_valid && a_req_ready && n_acc < 3) begin
                acc[n_acc] = c; n_acc++; take = 1;
            end
            a_rd_data = DATA_W'($urandom);
            step();
            if (take) begin
                if (n_acc == 1) begin a_req_write = 0; a_req_addr = 6'd1; end
                else if (n_acc == 2) begin a_req_write = 1; a_req_addr = 6'd2; a_req_wdata = 16'hC002; end
                else a_req_valid = 0;
            end
        end
        a_req_valid = 0;
        ld_model = 16'hC002;
        chk("b2b_count", n_acc, 3);
        chk("b2b_acc0", acc[0], 0);
        chk("b2b_acc1", acc[1], 3);
        chk("b2b_acc2", acc[2], 3 + LAT_A + 2);
        chk("b2b_rsp_pulses", n_rsp, 3);
        chk("b2b_stb_count", stb_seen.size(), 2);
        if (stb_seen.size() == 2) begin
            chk("b2b_stb0", stb_seen[0], 12'h001);
            chk("b2b_stb1", stb_seen[1], 12'h004);
        end
        chk("b2b_ld_data", a_ld_data, 16'hC002);

        // Randomised transactions against the rule-based expectations.
        for (int i = 0; i < 40; i++) begin
            addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 31));
            txn_a(1'($urandom), addr, DATA_W'($urandom), -1);
        end

        // RD_LAT = 3: rd_data changes every settle cycle, the third one is returned.
        for (int r = 0; r < 3; r++) begin
            addr = ADDR_W'($urandom_range(0, RD_COUNT - 1));
            esel = '0; esel[addr] = 1'b1;
            b_req_valid = 1; b_req_write = 0; b_req_addr = addr;
            step();
            b_req_valid = 0;
            last_b = '0;
            for (int k = 0; k < LAT_B; k++) begin
                chk("b_rd_sel", b_rd_sel, esel);
                chk("b_no_rsp", b_rsp_valid, 0);
                b_rd_data = DATA_W'($urandom);
                last_b = b_rd_data;
                step();
            end
            b_rd_data = ~last_b;
            chk("b_rsp_valid", b_rsp_valid, 1);
            chk("b_rsp_rdata", b_rsp_rdata, last_b);
            chk("b_rsp_err", b_rsp_err, 0);
            chk("b_ld_stb", b_ld_stb, 0);
            step();
            chk("b_ready", b_req_ready, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
